// File: rtl/pb_debounce_pkg.sv
// Shared constants for the push-button debouncer.
// STABLE_CYCLES_DEFAULT suits a ~1 ms window at 1 GHz-class clocks; SIM_STABLE_CYCLES keeps simulations short.
package pb_debounce_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 1000000;
  localparam int SIM_STABLE_CYCLES     = 4;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module pb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// Push-button debouncer with registered level and press/release strobes.
// Define PB_DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on button (+2 cycles latency).
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_s;
  logic [CNT_W-1:0] count;
  logic             differ;
  logic             expire;

`ifdef PB_DEBOUNCE_SYNC_EN
  pb_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (btn_s)
  );
`else
  assign btn_s = button;
`endif

  assign differ = btn_s ^ button_out;
  // Count stops at CNT_LAST and the level flips instead, so the counter can never wrap.
  assign expire = differ && (count == CNT_LAST);

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      button_out    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= expire &&  btn_s;
      release_pulse <= expire && !btn_s;
      if (!differ) begin
        count <= '0;
      end else if (expire) begin
        count      <= '0;
        button_out <= btn_s;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Directed, table-driven bench for pb_debounce with STABLE_CYCLES = 4.
// Latency expectations follow PB_DEBOUNCE_SYNC_EN (2 extra cycles when defined).
module tb_pb_debounce;
  import pb_debounce_pkg::*;

`ifdef PB_DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = SYNC_LAT + SIM_STABLE_CYCLES;

  typedef struct {
    logic rst_n;
    logic button;
    logic exp_out;
    logic exp_press;
    logic exp_release;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic button;
  logic button_out;
  logic press_pulse;
  logic release_pulse;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pb_debounce #(.STABLE_CYCLES(SIM_STABLE_CYCLES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .button_out    (button_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold rst/btn for n cycles; output switches ob->oa at offset chg (-1: never).
  task automatic add_run(input logic r, input logic b, input int n, input int chg,
                         input logic ob, input logic oa);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst_n       = r;
      v.button      = b;
      v.exp_out     = (chg >= 0 && i >= chg) ? oa : ob;
      v.exp_press   = (i == chg) && oa && !ob;
      v.exp_release = (i == chg) && !oa && ob;
      vecs.push_back(v);
    end
  endtask

  initial begin
    int lat;
    logic seen;

    rst_n  = 1'b0;
    button = 1'b0;

    // Reset for 100 ns, then idle.
    add_run(1'b0, 1'b0, 10, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b0, 10, -1, 1'b0, 1'b0);
    // Clean press, then clean release.
    add_run(1'b1, 1'b1, LAT + 3, LAT - 1, 1'b0, 1'b1);
    add_run(1'b1, 1'b0, LAT + 3, LAT - 1, 1'b1, 1'b0);
    // Bounce 1,0,1,0 then hold 1; then release again.
    add_run(1'b1, 1'b1, 1, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b0, 1, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b1, 1, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b0, 1, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b1, LAT + 3, LAT - 1, 1'b0, 1'b1);
    add_run(1'b1, 1'b0, LAT + 3, LAT - 1, 1'b1, 1'b0);
    // Glitch of 3 cycles is rejected.
    add_run(1'b1, 1'b1, 3, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b0, LAT + 3, -1, 1'b0, 1'b0);
    // Reset mid-count, then press completes relative to reset release.
    add_run(1'b1, 1'b1, 2, -1, 1'b0, 1'b0);
    add_run(1'b0, 1'b1, 2, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b1, LAT + 3, LAT - 1, 1'b0, 1'b1);
    // Reset while high clears output with no pulse; exit with button low stays quiet.
    add_run(1'b0, 1'b1, 2, -1, 1'b0, 1'b0);
    add_run(1'b1, 1'b0, LAT + 3, -1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n  = vecs[i].rst_n;
      button = vecs[i].button;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            int'({button_out, press_pulse, release_pulse}),
            int'({vecs[i].exp_out, vecs[i].exp_press, vecs[i].exp_release}));
    end

    // Press latency measured with a bounded wait.
    @(negedge clk);
    button = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (button_out) begin
        lat = c;
        break;
      end
    end
    check("press_latency", lat, LAT);
    check("press_pulse_on", int'(press_pulse), 1);
    check("release_quiet_on_press", int'(release_pulse), 0);
    @(posedge clk);
    #1;
    check("press_pulse_one_cycle", int'(press_pulse), 0);
    check("held_high", int'(button_out), 1);

    // Asynchronous reset between edges clears outputs at once.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", int'({button_out, press_pulse, release_pulse}), 0);

    // Exit reset with button low: no strobe of either kind.
    @(negedge clk);
    rst_n  = 1'b1;
    button = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk);
      #1;
      seen = seen | press_pulse | release_pulse | button_out;
    end
    check("no_pulse_after_reset_exit", int'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000000, number of consecutive clk cycles the synchronized input must differ from button_out before button_out follows it (legal range 2..2^24).
REQ-002 Parameter CNT_W, default $clog2(STABLE_CYCLES), stability counter width; derived, never overridden.
REQ-003 Port clk, input, 1, single system clock; all state is on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port button, input, 1, raw asynchronous, bouncy push-button level; active-high.
REQ-006 Port button_out, output, 1, debounced button level, registered.
REQ-007 Port press_pulse, output, 1, one-cycle strobe on each debounced 0->1 transition, registered.
REQ-008 Port release_pulse, output, 1, one-cycle strobe on each debounced 1->0 transition, registered.

Function
REQ-009 Internal signal btn_s is button after the input stage defined in Configuration.
REQ-010 In any cycle where btn_s equals button_out, the counter clears to 0 and button_out holds.
REQ-011 In any cycle where btn_s differs from button_out and counter < STABLE_CYCLES-1, the counter increments by 1.
REQ-012 In the cycle where btn_s differs and counter == STABLE_CYCLES-1, button_out takes btn_s at the next edge and the counter clears.
REQ-013 The net effect: button_out changes exactly STABLE_CYCLES cycles after btn_s first differs, provided btn_s differs in every one of those cycles.
REQ-014 Any single cycle where btn_s equals button_out restarts the count from 0, so glitches shorter than STABLE_CYCLES never reach button_out.
REQ-015 press_pulse is 1 for exactly the one cycle in which button_out is first 1 after a 0->1 update; release_pulse behaves the same way for 1->0.
REQ-016 press_pulse and release_pulse are never both 1.
REQ-017 The counter saturates by construction and never wraps; its width covers STABLE_CYCLES-1.

Reset
REQ-018 While rst_n is 0, all of the following are 0 and held there asynchronously: button_out, press_pulse, release_pulse, counter, and the synchronizer flops.
REQ-019 A button held high through the deassertion of reset yields button_out=1 after synchronizer latency plus STABLE_CYCLES cycles, with one press_pulse.
REQ-020 Reset asserted mid-count discards the partial count; no pulse is emitted on reset entry or exit.

Configuration
REQ-021 With macro PB_DEBOUNCE_SYNC_EN defined, btn_s is button passed through a two-flop synchronizer; this adds 2 cycles of latency.
REQ-022 Without PB_DEBOUNCE_SYNC_EN, btn_s is button used directly, and button is required to be synchronous to clk; latency is then exactly STABLE_CYCLES.

Structure
REQ-023 Package pb_debounce_pkg holds:
- the default STABLE_CYCLES constant;
- a simulation-friendly constant SIM_STABLE_CYCLES = 4.
REQ-024 Sub-module pb_sync, a two-flop reset-to-0 synchronizer, is instantiated only under PB_DEBOUNCE_SYNC_EN.

Verification
REQ-025 All scenarios use STABLE_CYCLES=4 with sync enabled. Reset then idle: rst_n low 100 ns, button=0 -> button_out, press_pulse and release_pulse stay 0 indefinitely.
REQ-026 Clean press: button 0->1 held -> button_out rises 6 cycles later (2 sync + 4), press_pulse high for exactly that one cycle.
REQ-027 Bounce: button toggles 1,0,1,0 at 1-cycle intervals, then holds 1 -> button_out rises exactly 6 cycles after the final 0->1 change, with a single press_pulse.
REQ-028 Glitch rejection: button high for 3 cycles, then low -> button_out remains 0 and no pulse occurs.
REQ-029 Clean release: from button_out=1, button 1->0 held -> button_out falls 6 cycles later, release_pulse high for 1 cycle.
REQ-030 Reset mid-count: button high, rst_n pulsed low 2 cycles after the edge -> outputs 0 immediately; after release, button_out rises 6 cycles after reset deassertion.
